// File: rtl/bp_aes_sbox_fwd_word_if.sv
// Handshake bundle for the serial forward SubWord engine.
// The in_rot lane exists only when BP_SBOX_FWD_ROTWORD_EN is defined.
interface bp_aes_sbox_fwd_word_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
`ifdef BP_SBOX_FWD_ROTWORD_EN
    logic        in_rot;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

`ifdef BP_SBOX_FWD_ROTWORD_EN
    modport master (output in_valid, in_data, in_rot, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, in_rot, out_ready,
                    output in_ready, out_valid, out_data);
`else
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/bp_aes_sbox_fwd_word.sv
// Serial AES SubWord: four bytes through one Boyar-Peralta forward S-box, one per cycle.
// Optional RotWord on input when BP_SBOX_FWD_ROTWORD_EN is defined.
module bp_aes_sbox_fwd_word (
    input  logic                          g_clk,
    input  logic                          g_resetn,
    bp_aes_sbox_fwd_word_if.slave         bus
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t      state, next_state;
    logic [1:0]  cnt;
    logic [31:0] work, result;
    logic [7:0]  sub_in, sub_out;
    logic        accept;

    // Boyar-Peralta depth-16 forward S-box; u[0]/s[0] are the byte MSBs.
    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [0:7]  u;
        logic [27:1] t;
        logic [63:1] m;
        logic [29:0] l;
        logic [0:7]  s;
        u = x;
        t[1]  = u[0] ^ u[3];   t[2]  = u[0] ^ u[5];   t[3]  = u[0] ^ u[6];
        t[4]  = u[3] ^ u[5];   t[5]  = u[4] ^ u[6];   t[6]  = t[1] ^ t[5];
        t[7]  = u[1] ^ u[2];   t[8]  = u[7] ^ t[6];   t[9]  = u[7] ^ t[7];
        t[10] = t[6] ^ t[7];   t[11] = u[1] ^ u[5];   t[12] = u[2] ^ u[5];
        t[13] = t[3] ^ t[4];   t[14] = t[6] ^ t[11];  t[15] = t[5] ^ t[11];
        t[16] = t[5] ^ t[12];  t[17] = t[9] ^ t[16];  t[18] = u[3] ^ u[7];
        t[19] = t[7] ^ t[18];  t[20] = t[1] ^ t[19];  t[21] = u[6] ^ u[7];
        t[22] = t[7] ^ t[21];  t[23] = t[2] ^ t[22];  t[24] = t[2] ^ t[10];
        t[25] = t[20] ^ t[17]; t[26] = t[3] ^ t[16];  t[27] = t[1] ^ t[12];

        m[1]  = t[13] & t[6];  m[2]  = t[23] & t[8];  m[3]  = t[14] ^ m[1];
        m[4]  = t[19] & u[7];  m[5]  = m[4] ^ m[1];   m[6]  = t[3] & t[16];
        m[7]  = t[22] & t[9];  m[8]  = t[26] ^ m[6];  m[9]  = t[20] & t[17];
        m[10] = m[9] ^ m[6];   m[11] = t[1] & t[15];  m[12] = t[4] & t[27];
        m[13] = m[12] ^ m[11]; m[14] = t[2] & t[10];  m[15] = m[14] ^ m[11];
        m[16] = m[3] ^ m[2];   m[17] = m[5] ^ t[24];  m[18] = m[8] ^ m[7];
        m[19] = m[10] ^ m[15]; m[20] = m[16] ^ m[13]; m[21] = m[17] ^ m[15];
        m[22] = m[18] ^ m[13]; m[23] = m[19] ^ t[25]; m[24] = m[22] ^ m[23];
        m[25] = m[22] & m[20]; m[26] = m[21] ^ m[25]; m[27] = m[20] ^ m[21];
        m[28] = m[23] ^ m[25]; m[29] = m[28] & m[27]; m[30] = m[26] & m[24];
        m[31] = m[20] & m[23]; m[32] = m[27] & m[31]; m[33] = m[27] ^ m[25];
        m[34] = m[21] & m[22]; m[35] = m[24] & m[34]; m[36] = m[24] ^ m[25];
        m[37] = m[21] ^ m[29]; m[38] = m[32] ^ m[33]; m[39] = m[23] ^ m[30];
        m[40] = m[35] ^ m[36]; m[41] = m[38] ^ m[40]; m[42] = m[37] ^ m[39];
        m[43] = m[37] ^ m[38]; m[44] = m[39] ^ m[40]; m[45] = m[42] ^ m[41];
        m[46] = m[44] & t[6];  m[47] = m[40] & t[8];  m[48] = m[39] & u[7];
        m[49] = m[43] & t[16]; m[50] = m[38] & t[9];  m[51] = m[37] & t[17];
        m[52] = m[42] & t[15]; m[53] = m[45] & t[27]; m[54] = m[41] & t[10];
        m[55] = m[44] & t[13]; m[56] = m[40] & t[23]; m[57] = m[39] & t[19];
        m[58] = m[43] & t[3];  m[59] = m[38] & t[22]; m[60] = m[37] & t[20];
        m[61] = m[42] & t[1];  m[62] = m[45] & t[4];  m[63] = m[41] & t[2];

        l[0]  = m[61] ^ m[62]; l[1]  = m[50] ^ m[56]; l[2]  = m[46] ^ m[48];
        l[3]  = m[47] ^ m[55]; l[4]  = m[54] ^ m[58]; l[5]  = m[49] ^ m[61];
        l[6]  = m[62] ^ l[5];  l[7]  = m[46] ^ l[3];  l[8]  = m[51] ^ m[59];
        l[9]  = m[52] ^ m[53]; l[10] = m[53] ^ l[4];  l[11] = m[60] ^ l[2];
        l[12] = m[48] ^ m[51]; l[13] = m[50] ^ l[0];  l[14] = m[52] ^ m[61];
        l[15] = m[55] ^ l[1];  l[16] = m[56] ^ l[0];  l[17] = m[57] ^ l[1];
        l[18] = m[58] ^ l[8];  l[19] = m[63] ^ l[4];  l[20] = l[0] ^ l[1];
        l[21] = l[1] ^ l[7];   l[22] = l[3] ^ l[12];  l[23] = l[18] ^ l[2];
        l[24] = l[15] ^ l[9];  l[25] = l[6] ^ l[10];  l[26] = l[7] ^ l[9];
        l[27] = l[8] ^ l[10];  l[28] = l[11] ^ l[14]; l[29] = l[11] ^ l[17];

        s[0] = l[6] ^ l[24];     s[1] = ~(l[16] ^ l[26]);
        s[2] = ~(l[19] ^ l[28]); s[3] = l[6] ^ l[21];
        s[4] = l[20] ^ l[22];    s[5] = l[25] ^ l[29];
        s[6] = ~(l[13] ^ l[27]); s[7] = ~(l[6] ^ l[23]);
        return s;
    endfunction

    // Control: DONE hands in_ready to the consumer so a new word can chain without an idle cycle.
    always_comb begin
        next_state    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) next_state = BUSY;
            end
            BUSY: begin
                if (cnt == 2'd3) next_state = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
                if (bus.out_ready) next_state = bus.in_valid ? BUSY : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign accept       = bus.in_valid & bus.in_ready;
    assign sub_in       = work[{cnt, 3'b000} +: 8];
    assign sub_out      = sbox_fwd(sub_in);
    assign bus.out_data = result;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) state <= IDLE;
        else           state <= next_state;
    end

    // Datapath: latch on acceptance, then substitute byte cnt into result each BUSY cycle.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            work   <= 32'd0;
            result <= 32'd0;
            cnt    <= 2'd0;
        end else if (accept) begin
`ifdef BP_SBOX_FWD_ROTWORD_EN
            work <= bus.in_rot ? {bus.in_data[23:0], bus.in_data[31:24]} : bus.in_data;
`else
            work <= bus.in_data;
`endif
            cnt  <= 2'd0;
        end else if (state == BUSY) begin
            result[{cnt, 3'b000} +: 8] <= sub_out;
            cnt                        <= cnt + 2'd1;
        end
    end

endmodule

// File: tb/tb_bp_aes_sbox_fwd_word.sv
// Bench for bp_aes_sbox_fwd_word: GF(2^8) reference model plus directed vectors.
// Define BP_SBOX_FWD_ROTWORD_EN to also exercise the RotWord option.
module tb_bp_aes_sbox_fwd_word;

    logic g_clk = 1'b0;
    logic g_resetn = 1'b0;
    always #5 g_clk = ~g_clk;

    bp_aes_sbox_fwd_word_if bus ();
    bp_aes_sbox_fwd_word dut (.g_clk(g_clk), .g_resetn(g_resetn), .bus(bus));

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] sbox_tab [256];
    logic [7:0] inv_tab  [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'd0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // FIPS-197: multiplicative inverse in GF(2^8), then the affine map with constant 0x63.
    task automatic build_tables();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'd0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox_tab[x] = s;
            inv_tab[s]  = 8'(x);
        end
    endtask

    function automatic logic [31:0] model_subword(input logic [31:0] w, input logic rot);
        logic [31:0] v, r;
        v = rot ? {w[23:0], w[31:24]} : w;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = sbox_tab[v[8*k +: 8]];
        return r;
    endfunction

    function automatic logic cur_rot();
`ifdef BP_SBOX_FWD_ROTWORD_EN
        return bus.in_rot;
`else
        return 1'b0;
`endif
    endfunction

    // Cycle model: busy countdown of 4 cycles after acceptance, then a held result.
    int          m_busy = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_word = 32'd0;

    always @(negedge g_clk) begin
        logic exp_ready;
        if (!g_resetn) begin
            m_busy = 0;
            m_done = 1'b0;
        end else begin
            exp_ready = (m_busy == 0 && !m_done) || (m_done && bus.out_ready);
            check("cyc out_valid", {31'd0, bus.out_valid}, {31'd0, m_done});
            check("cyc in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
            if (m_done) check("cyc out_data", bus.out_data, m_word);
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_done = 1'b1;
            end else if (m_done && bus.out_ready) begin
                m_done = 1'b0;
            end
            if (exp_ready && bus.in_valid) begin
                m_word = model_subword(bus.in_data, cur_rot());
                m_busy = 4;
            end
        end
    end

    task automatic set_rot(input logic rot);
`ifdef BP_SBOX_FWD_ROTWORD_EN
        bus.in_rot = rot;
`else
        if (rot) $display("note: in_rot ignored in this build");
`endif
    endtask

    // Offer a word, then wait for and consume its result; lat counts negedges after acceptance.
    task automatic do_word(input logic [31:0] d, input logic rot,
                           output logic [31:0] r, output int lat);
        logic acc, got;
        int   n;
        bus.in_data   = d;
        set_rot(rot);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            @(negedge g_clk);
            acc = bus.in_ready;
            n++;
            @(posedge g_clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) check("accept timeout", 32'd0, 32'd1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge g_clk);
            lat++;
            got = bus.out_valid;
        end
        r = bus.out_data;
        if (!got) check("result timeout", 32'd0, 32'd1);
        @(posedge g_clk);
        #1;
    endtask

    task automatic wait_valid(output int lat);
        logic got;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge g_clk);
            lat++;
            got = bus.out_valid;
        end
        if (!got) check("result timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] r, held;
        int          lat;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.out_ready = 1'b0;
        set_rot(1'b0);
        build_tables();

        check("pin S(00)", {24'd0, sbox_tab[8'h00]}, 32'h63);
        check("pin S(10)", {24'd0, sbox_tab[8'h10]}, 32'hCA);
        check("pin S(52)", {24'd0, sbox_tab[8'h52]}, 32'h00);
        check("pin S(20)", {24'd0, sbox_tab[8'h20]}, 32'hB7);
        check("pin word", model_subword(32'h53FF0100, 1'b0), 32'hED167C63);

        #2;
        check("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst out_data", bus.out_data, 32'd0);
        repeat (2) @(posedge g_clk);
        #1 g_resetn = 1'b1;

        // basic word and latency
        do_word(32'h53FF0100, 1'b0, r, lat);
        check("basic data", r, 32'hED167C63);
        check("basic latency", 32'(lat), 32'd5);

        // every byte value, and the inverse of each result byte returns the input
        for (int x = 0; x < 256; x++) begin
            do_word({4{8'(x)}}, 1'b0, r, lat);
            check("inv(S(x))", {inv_tab[r[31:24]], inv_tab[r[23:16]], inv_tab[r[15:8]], inv_tab[r[7:0]]},
                  {4{8'(x)}});
        end
        do_word(32'h10101010, 1'b0, r, lat);
        check("S(10) word", r, 32'hCACACACA);
        do_word(32'h52525252, 1'b0, r, lat);
        check("S(52) word", r, 32'h00000000);

        // backpressure then back-to-back acceptance
        bus.in_data   = 32'h01010101;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge g_clk);
        @(posedge g_clk);
        #1 bus.in_valid = 1'b0;
        wait_valid(lat);
        held = bus.out_data;
        check("bp first data", held, 32'h7C7C7C7C);
        @(posedge g_clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            @(negedge g_clk);
            check("bp out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp out_data", bus.out_data, held);
            check("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
            @(posedge g_clk);
            #1;
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h20202020;
        @(negedge g_clk);
        check("b2b in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge g_clk);
        #1 bus.in_valid = 1'b0;
        wait_valid(lat);
        check("b2b latency", 32'(lat), 32'd5);
        check("b2b data", bus.out_data, 32'hB7B7B7B7);
        @(posedge g_clk);
        #1;

        // input activity during BUSY is ignored
        bus.in_data  = 32'h53FF0100;
        bus.in_valid = 1'b1;
        @(negedge g_clk);
        @(posedge g_clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = $urandom;
            @(posedge g_clk);
            #1;
        end
        bus.in_valid = 1'b0;
        wait_valid(lat);
        check("ignore data", bus.out_data, 32'hED167C63);
        @(posedge g_clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge g_clk);
            check("ignore no extra", {31'd0, bus.out_valid}, 32'd0);
        end
        @(posedge g_clk);
        #1;

        // async reset mid-BUSY
        bus.in_data  = 32'hAABBCCDD;
        bus.in_valid = 1'b1;
        @(negedge g_clk);
        @(posedge g_clk);
        #1 bus.in_valid = 1'b0;
        @(posedge g_clk);
        #3 g_resetn = 1'b0;
        #1;
        check("arst in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("arst out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst out_data", bus.out_data, 32'd0);
        @(posedge g_clk);
        #1 g_resetn = 1'b1;
        do_word(32'h00000000, 1'b0, r, lat);
        check("post-rst data", r, 32'h63636363);
        check("post-rst latency", 32'(lat), 32'd5);

`ifdef BP_SBOX_FWD_ROTWORD_EN
        do_word(32'h53FF0100, 1'b1, r, lat);
        check("rot=1 data", r, 32'h167C63ED);
        do_word(32'h53FF0100, 1'b0, r, lat);
        check("rot=0 data", r, 32'hED167C63);
`endif

        repeat (3) @(posedge g_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
